axis_straddle_splitter: RTL and testbench

Parametrised successor to the two-lane straddle converter. It accepts a DATA_W-bit AXI-Stream whose beats are divided into SEG_COUNT equal segments, any of which may start or end a packet. It emits an unstraddled stream with exactly one packet fragment per output beat, in original packet order. It sits between the PCIe completion/request stream and the switch fabric, buffering input beats in a FIFO_DEPTH-entry FIFO.

---
 rtl/axis_straddle_splitter.sv | 199 +++++++++++++++++++
 tb/tb_axis_straddle_splitter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_straddle_splitter.sv
// Splits a segmented, straddled AXI-Stream into an unstraddled stream carrying
// exactly one packet fragment per output beat, behind a small input beat FIFO.
module axis_straddle_splitter #(
    parameter int DATA_W     = 512,
    parameter int SEG_COUNT  = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [DATA_W-1:0]      S_AXIS_TDATA,
    input  logic [DATA_W/32-1:0]   S_AXIS_TKEEP,
    input  logic [SEG_COUNT-1:0]   S_AXIS_TSOP,
    input  logic [SEG_COUNT-1:0]   S_AXIS_TEOP,
    input  logic                   S_AXIS_TDISC,
    input  logic                   S_AXIS_TVALID,
    output logic                   S_AXIS_TREADY,
    output logic [DATA_W-1:0]      M_AXIS_TDATA,
    output logic [DATA_W/32-1:0]   M_AXIS_TKEEP,
    output logic [SEG_COUNT-1:0]   M_AXIS_TSEG,
    output logic                   M_AXIS_TLAST,
    output logic                   M_AXIS_TDISC,
    output logic                   M_AXIS_TVALID,
    input  logic                   M_AXIS_TREADY,
    output logic [1:0]             error_invalid_state,
    output logic [31:0]            pkt_count
);
    // state | meaning
    // IDLE  | no unscanned beat waiting in the FIFO
    // EMIT  | walking the fragments of the head beat, one per cycle

    localparam int SEG_W  = DATA_W / SEG_COUNT;
    localparam int KEEP_W = DATA_W / 32;
    localparam int SK_W   = SEG_W / 32;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = AW + 1;
    localparam int PW     = $clog2(SEG_COUNT + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    logic [DATA_W-1:0]    mem_data [FIFO_DEPTH];
    logic [KEEP_W-1:0]    mem_keep [FIFO_DEPTH];
    logic [SEG_COUNT-1:0] mem_sop  [FIFO_DEPTH];
    logic [SEG_COUNT-1:0] mem_eop  [FIFO_DEPTH];
    logic                 mem_disc [FIFO_DEPTH];

    state_t               state;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [OCC_W-1:0]     occ, scnt, scnt_next;
    logic [PW-1:0]        pos, n_pos;
    logic                 open_q, out_rel;

    logic [DATA_W-1:0]    h_data, f_data;
    logic [KEEP_W-1:0]    h_keep, f_keep;
    logic [SEG_COUNT-1:0] h_sop, h_eop, f_mask;
    logic                 h_disc;
    logic                 scan_open, scan_done, tail_sop;
    logic                 f_last, f_force, e_sop, e_eop;
    logic                 has_frag, beat_end, advance, push, pop, m_hs, rel_hs, rel_skip;

    // occ counts every beat not yet fully delivered, including the one whose
    // last fragment is still sitting in the output register
    assign S_AXIS_TREADY = (occ != OCC_W'(FIFO_DEPTH));
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_data[wr_ptr] <= S_AXIS_TDATA;
            mem_keep[wr_ptr] <= S_AXIS_TKEEP;
            mem_sop[wr_ptr]  <= S_AXIS_TSOP;
            mem_eop[wr_ptr]  <= S_AXIS_TEOP;
            mem_disc[wr_ptr] <= S_AXIS_TDISC;
        end
    end

    assign h_data = mem_data[rd_ptr];
    assign h_keep = mem_keep[rd_ptr];
    assign h_sop  = mem_sop[rd_ptr];
    assign h_eop  = mem_eop[rd_ptr];
    assign h_disc = mem_disc[rd_ptr];

    // Scan from pos for the next fragment; past its end keep looking for a
    // later SOP (more fragments) and for stray EOPs before it.
    always_comb begin
        scan_open = open_q;
        scan_done = 1'b0;
        tail_sop  = 1'b0;
        f_mask    = '0;
        f_last    = 1'b0;
        f_force   = 1'b0;
        e_sop     = 1'b0;
        e_eop     = 1'b0;
        n_pos     = PW'(SEG_COUNT);
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (i >= int'(pos)) begin
                if (scan_done) begin
                    if (h_sop[i]) begin
                        tail_sop = 1'b1;
                    end else if (h_eop[i] && !tail_sop) begin
                        e_eop = 1'b1;
                    end
                end else if (!scan_open) begin
                    if (h_sop[i]) begin
                        scan_open = 1'b1;
                        f_mask[i] = 1'b1;
                        if (h_eop[i]) begin
                            scan_open = 1'b0;
                            f_last    = 1'b1;
                            scan_done = 1'b1;
                            n_pos     = PW'(i + 1);
                        end
                    end else if (h_eop[i]) begin
                        e_eop = 1'b1;
                    end
                end else if (h_sop[i]) begin
                    e_sop     = 1'b1;
                    f_last    = 1'b1;
                    f_force   = 1'b1;
                    scan_open = 1'b0;
                    scan_done = 1'b1;
                    tail_sop  = 1'b1;
                    n_pos     = PW'(i);
                end else begin
                    f_mask[i] = 1'b1;
                    if (h_eop[i]) begin
                        scan_open = 1'b0;
                        f_last    = 1'b1;
                        scan_done = 1'b1;
                        n_pos     = PW'(i + 1);
                    end
                end
            end
        end
        f_data = '0;
        f_keep = '0;
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (f_mask[i]) begin
                f_data[i*SEG_W +: SEG_W] = h_data[i*SEG_W +: SEG_W];
                f_keep[i*SK_W +: SK_W]   = h_keep[i*SK_W +: SK_W];
            end
        end
    end

    assign has_frag  = (f_mask != '0) || f_force;
    assign beat_end  = !tail_sop;
    assign m_hs      = M_AXIS_TVALID && M_AXIS_TREADY;
    assign advance   = (state == EMIT) && (!has_frag || !M_AXIS_TVALID || M_AXIS_TREADY);
    assign pop       = advance && beat_end;
    assign rel_hs    = m_hs && out_rel;
    assign rel_skip  = advance && !has_frag;
    assign scnt_next = scnt + OCC_W'(push) - OCC_W'(pop);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            occ                 <= '0;
            scnt                <= '0;
            pos                 <= '0;
            open_q              <= 1'b0;
            out_rel             <= 1'b0;
            M_AXIS_TVALID       <= 1'b0;
            M_AXIS_TDATA        <= '0;
            M_AXIS_TKEEP        <= '0;
            M_AXIS_TSEG         <= '0;
            M_AXIS_TLAST        <= 1'b0;
            M_AXIS_TDISC        <= 1'b0;
            error_invalid_state <= 2'b00;
            pkt_count           <= '0;
        end else begin
            state  <= (scnt_next != '0) ? EMIT : IDLE;
            wr_ptr <= wr_ptr + AW'(push);
            scnt   <= scnt_next;
            occ    <= occ + OCC_W'(push) - OCC_W'(rel_hs) - OCC_W'(rel_skip);
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (advance) begin
                pos                 <= beat_end ? '0 : n_pos;
                open_q              <= scan_open;
                error_invalid_state <= error_invalid_state | {e_sop, e_eop};
            end
            if (advance && has_frag) begin
                M_AXIS_TVALID <= 1'b1;
                M_AXIS_TDATA  <= f_data;
                M_AXIS_TKEEP  <= f_keep;
                M_AXIS_TSEG   <= f_mask;
                M_AXIS_TLAST  <= f_last;
                M_AXIS_TDISC  <= f_force || (h_disc && f_last);
                out_rel       <= beat_end;
            end else if (M_AXIS_TREADY) begin
                M_AXIS_TVALID <= 1'b0;
            end
            if (m_hs && M_AXIS_TLAST) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_straddle_splitter.sv
// Bench for axis_straddle_splitter: table of beats with hand-derived fragments,
// plus stall/backpressure and mid-packet reset sequences.
module tb_axis_straddle_splitter;
    localparam int DW = 512;
    localparam int KW = 16;
    localparam int SW = 128;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [DW-1:0] S_AXIS_TDATA;
    logic [KW-1:0] S_AXIS_TKEEP;
    logic [3:0]    S_AXIS_TSOP, S_AXIS_TEOP;
    logic          S_AXIS_TDISC, S_AXIS_TVALID, S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic [KW-1:0] M_AXIS_TKEEP;
    logic [3:0]    M_AXIS_TSEG;
    logic          M_AXIS_TLAST, M_AXIS_TDISC, M_AXIS_TVALID, M_AXIS_TREADY;
    logic [1:0]    error_invalid_state;
    logic [31:0]   pkt_count;

    axis_straddle_splitter #(.DATA_W(DW), .SEG_COUNT(4), .FIFO_DEPTH(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
        .S_AXIS_TSOP(S_AXIS_TSOP), .S_AXIS_TEOP(S_AXIS_TEOP),
        .S_AXIS_TDISC(S_AXIS_TDISC), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TSEG(M_AXIS_TSEG), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TDISC(M_AXIS_TDISC), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .error_invalid_state(error_invalid_state), .pkt_count(pkt_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [3:0]      sop;
        logic [3:0]      eop;
        logic            disc;
        logic [KW-1:0]   keep;
        logic [2:0]      nf;
        logic [3:0][3:0] fs;    // fragment k segment mask in fs[k]
        logic [3:0]      fl;
        logic [3:0]      fd;
        logic [1:0]      err;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [3:0]    s;
        logic          l;
        logic          ds;
    } frag_t;

    frag_t exp_q[$];
    vec_t  tbl[12];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] sop, input logic [3:0] eop, input logic disc,
                                input logic [KW-1:0] keep, input logic [2:0] nf,
                                input logic [15:0] fs, input logic [3:0] fl,
                                input logic [3:0] fd, input logic [1:0] err);
        vec_t v;
        v.sop = sop; v.eop = eop; v.disc = disc; v.keep = keep; v.nf = nf;
        v.fs = fs; v.fl = fl; v.fd = fd; v.err = err;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic frag_t mk_frag(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                      input logic [3:0] s, input logic l, input logic ds);
        frag_t f;
        f.d = '0; f.k = '0; f.s = s; f.l = l; f.ds = ds;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                f.d[i*SW +: SW] = d[i*SW +: SW];
                f.k[i*4 +: 4]   = k[i*4 +: 4];
            end
        end
        return f;
    endfunction

    // scoreboard: pop one expected fragment per M handshake
    always @(negedge ACLK) begin
        frag_t e;
        if (ARESETN === 1'b1 && M_AXIS_TVALID && M_AXIS_TREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fragment actual_seg=%b required=none", M_AXIS_TSEG);
            end else begin
                e = exp_q.pop_front();
                chk("m_tseg", M_AXIS_TSEG, e.s);
                chk("m_tlast", M_AXIS_TLAST, e.l);
                chk("m_tdisc", M_AXIS_TDISC, e.ds);
                chk("m_tkeep", M_AXIS_TKEEP, e.k);
                chk_wide("m_tdata", M_AXIS_TDATA, e.d);
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic [3:0] s, input logic [3:0] e, input logic ds);
        int n;
        @(posedge ACLK);
        #1;
        S_AXIS_TDATA = d; S_AXIS_TKEEP = k; S_AXIS_TSOP = s; S_AXIS_TEOP = e;
        S_AXIS_TDISC = ds; S_AXIS_TVALID = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!S_AXIS_TREADY && n < 200) begin
            n++;
            @(negedge ACLK);
        end
        if (!S_AXIS_TREADY) chk("s_tready_timeout", S_AXIS_TREADY, 1);
        @(posedge ACLK);
        #1;
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge ACLK);
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (3) @(negedge ACLK);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] snap_d;
        logic [3:0]    snap_s;
        logic          rdy;
        int            pkt_exp, acc, unstable, n;

        tbl[0]  = mk(4'b0001, 4'b1000, 0, 16'hFFFF, 1, 16'h000F, 4'b0001, 4'b0000, 2'b00);
        tbl[1]  = mk(4'b0001, 4'b0000, 0, 16'hFFFF, 1, 16'h000F, 4'b0000, 4'b0000, 2'b00);
        tbl[2]  = mk(4'b0110, 4'b0011, 1, 16'hFFFF, 3, 16'h0C21, 4'b0011, 4'b0011, 2'b00);
        tbl[3]  = mk(4'b0000, 4'b0001, 0, 16'h0A5F, 1, 16'h0001, 4'b0001, 4'b0000, 2'b00);
        tbl[4]  = mk(4'b1111, 4'b1111, 1, 16'hFFFF, 4, 16'h8421, 4'b1111, 4'b1111, 2'b00);
        tbl[5]  = mk(4'b0001, 4'b0000, 0, 16'hFFFF, 1, 16'h000F, 4'b0000, 4'b0000, 2'b00);
        tbl[6]  = mk(4'b0100, 4'b1000, 0, 16'hFFFF, 2, 16'h00C3, 4'b0011, 4'b0001, 2'b10);
        tbl[7]  = mk(4'b0000, 4'b0000, 1, 16'h1234, 0, 16'h0000, 4'b0000, 4'b0000, 2'b10);
        tbl[8]  = mk(4'b0000, 4'b0100, 0, 16'hFFFF, 0, 16'h0000, 4'b0000, 4'b0000, 2'b11);
        tbl[9]  = mk(4'b0010, 4'b0100, 1, 16'hF0F0, 1, 16'h0006, 4'b0001, 4'b0001, 2'b11);
        tbl[10] = mk(4'b1000, 4'b0000, 0, 16'hFFFF, 1, 16'h0008, 4'b0000, 4'b0000, 2'b11);
        tbl[11] = mk(4'b0000, 4'b0001, 0, 16'hFFFF, 1, 16'h0001, 4'b0001, 4'b0000, 2'b11);

        ARESETN = 1'b0;
        S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0; S_AXIS_TSOP = '0; S_AXIS_TEOP = '0;
        S_AXIS_TDISC = 1'b0; S_AXIS_TVALID = 1'b0; M_AXIS_TREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("rst_s_tready", S_AXIS_TREADY, 1);
        chk("rst_m_tvalid", M_AXIS_TVALID, 0);
        chk("rst_m_tseg", M_AXIS_TSEG, 0);
        chk("rst_err", error_invalid_state, 0);
        chk("rst_pkt", pkt_count, 0);

        pkt_exp = 0;
        for (int v = 0; v < 12; v++) begin
            d = rand_data();
            for (int k = 0; k < int'(tbl[v].nf); k++)
                exp_q.push_back(mk_frag(d, tbl[v].keep, tbl[v].fs[k], tbl[v].fl[k], tbl[v].fd[k]));
            send_beat(d, tbl[v].keep, tbl[v].sop, tbl[v].eop, tbl[v].disc);
            wait_drain();
            pkt_exp += $countones(tbl[v].fl);
            chk($sformatf("err_v%0d", v), error_invalid_state, tbl[v].err);
            chk($sformatf("pkt_v%0d", v), pkt_count, pkt_exp);
        end

        // Backpressure: 40 cycles with M stalled and input always offered
        @(posedge ACLK);
        #1;
        M_AXIS_TREADY = 1'b0;
        acc = 0; unstable = 0; snap_d = '0; snap_s = '0;
        d = rand_data();
        S_AXIS_TDATA = d; S_AXIS_TKEEP = 16'hFFFF; S_AXIS_TSOP = 4'b0001;
        S_AXIS_TEOP = 4'b1000; S_AXIS_TDISC = 1'b0; S_AXIS_TVALID = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge ACLK);
            rdy = S_AXIS_TREADY;
            if (c == 4) begin
                chk("stall_m_tvalid", M_AXIS_TVALID, 1);
                snap_d = M_AXIS_TDATA;
                snap_s = M_AXIS_TSEG;
            end else if (c > 4) begin
                if (!M_AXIS_TVALID || M_AXIS_TDATA !== snap_d || M_AXIS_TSEG !== snap_s)
                    unstable++;
            end
            @(posedge ACLK);
            #1;
            if (rdy) begin
                exp_q.push_back(mk_frag(d, 16'hFFFF, 4'b1111, 1'b1, 1'b0));
                acc++;
                d = rand_data();
                S_AXIS_TDATA = d;
            end
        end
        S_AXIS_TVALID = 1'b0;
        @(negedge ACLK);
        chk("stall_accepted", acc, 16);
        chk("stall_s_tready", S_AXIS_TREADY, 0);
        chk("stall_unstable_cycles", unstable, 0);
        @(posedge ACLK);
        #1;
        M_AXIS_TREADY = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge ACLK);
        end
        chk("release_drained", exp_q.size(), 0);
        checks++;
        if (n > 18) begin
            failures++;
            $display("FAIL release_cycles actual=%0d required<=18", n);
        end
        wait_drain();
        pkt_exp += 16;
        chk("pkt_after_stall", pkt_count, pkt_exp);

        // Mid-packet reset: open packet, one more beat buffered and stalled
        d = rand_data();
        exp_q.push_back(mk_frag(d, 16'hFFFF, 4'b1111, 1'b0, 1'b0));
        send_beat(d, 16'hFFFF, 4'b0001, 4'b0000, 1'b0);
        wait_drain();
        @(posedge ACLK);
        #1 M_AXIS_TREADY = 1'b0;
        send_beat(rand_data(), 16'hFFFF, 4'b0000, 4'b0000, 1'b0);
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b0;
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("mrst_m_tvalid", M_AXIS_TVALID, 0);
        chk("mrst_s_tready", S_AXIS_TREADY, 1);
        chk("mrst_pkt", pkt_count, 0);
        chk("mrst_err", error_invalid_state, 0);
        @(posedge ACLK);
        #1 M_AXIS_TREADY = 1'b1;
        d = rand_data();
        exp_q.push_back(mk_frag(d, 16'h0FFF, 4'b1111, 1'b1, 1'b0));
        send_beat(d, 16'h0FFF, 4'b0001, 4'b1000, 1'b0);
        wait_drain();
        chk("post_rst_pkt", pkt_count, 1);
        chk("post_rst_err", error_invalid_state, 0);
        chk("post_rst_s_tready", S_AXIS_TREADY, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
